// File: rtl/zigzag_stream.sv
// Streaming N x N coefficient reorderer: raster-order input, zig-zag (mode 0) or
// raster (mode 1) output, double-buffered so one block fills while the other drains.
// Optional end-of-block tracking (eob_out) is enabled by defining ZIGZAG_EOB_EN.
module zigzag_stream #(
  parameter int DATA_WIDTH = 11,
  parameter int N          = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    valid_in,
  input  logic                    mode_in,
  output logic                    ready_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [$clog2(N*N)-1:0]  index_out,
  output logic                    last_out,
  output logic                    valid_out,
  input  logic                    ready_in
`ifdef ZIGZAG_EOB_EN
  ,
  output logic [$clog2(N*N):0]    eob_out
`endif
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int RW = $clog2(N);

  logic [DATA_WIDTH-1:0] r_mem [2][NN];
  logic [1:0]            r_full;       // bank holds a complete, not yet drained block
  logic [1:0]            r_bank_mode;  // mode captured at each bank's first beat
  logic                  r_wr_bank;
  logic [IW-1:0]         r_wr_cnt;
  logic                  r_rd_bank;
  logic [IW-1:0]         r_rd_idx;
  logic [RW-1:0]         r_row;
  logic [RW-1:0]         r_col;
  logic                  r_up;

  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_wr_last;
  logic                  w_rd_last;
  logic                  w_rd_raster;
  logic [IW-1:0]         w_rd_addr;
  logic [1:0]            w_full_d;
  logic [RW-1:0]         w_row_nx;
  logic [RW-1:0]         w_col_nx;
  logic                  w_up_nx;

  assign ready_out   = !r_full[r_wr_bank];
  assign valid_out   = r_full[r_rd_bank];
  assign w_wr_hs     = valid_in && ready_out;
  assign w_rd_hs     = valid_out && ready_in;
  assign w_wr_last   = (r_wr_cnt == IW'(NN - 1));
  assign w_rd_last   = (r_rd_idx == IW'(NN - 1));
  assign w_rd_raster = r_bank_mode[r_rd_bank];
  assign w_rd_addr   = w_rd_raster ? r_rd_idx : IW'(int'(r_row) * N + int'(r_col));

  // Outputs are forced to zero while idle so reset/idle values are deterministic.
  assign data_out  = valid_out ? r_mem[r_rd_bank][w_rd_addr] : '0;
  assign index_out = r_rd_idx;
  assign last_out  = valid_out && w_rd_last;

  // Coefficient storage: the writer only ever targets a bank that is not full.
  always_ff @(posedge clk_in) begin
    if (w_wr_hs) begin
      r_mem[r_wr_bank][r_wr_cnt] <= data_in;
    end
  end

  // Write side: beat counter, bank toggle and per-bank mode capture.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_bank_mode <= '0;
    end else if (w_wr_hs) begin
      if (r_wr_cnt == '0) begin
        r_bank_mode[r_wr_bank] <= mode_in;
      end
      if (w_wr_last) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_cnt <= r_wr_cnt + IW'(1);
      end
    end
  end

  // Bank status: writer and reader always touch different banks, so both may update at once.
  always_comb begin
    w_full_d = r_full;
    if (w_wr_hs && w_wr_last) w_full_d[r_wr_bank] = 1'b1;
    if (w_rd_hs && w_rd_last) w_full_d[r_rd_bank] = 1'b0;
  end

  // Bank status register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_full <= '0;
    else        r_full <= w_full_d;
  end

  // Zig-zag walker next position; raster mode reads by index and leaves the walker parked.
  always_comb begin
    w_row_nx = r_row;
    w_col_nx = r_col;
    w_up_nx  = r_up;
    if (r_up) begin
      if (r_col == RW'(N - 1)) begin
        w_row_nx = r_row + RW'(1);
        w_up_nx  = 1'b0;
      end else if (r_row == '0) begin
        w_col_nx = r_col + RW'(1);
        w_up_nx  = 1'b0;
      end else begin
        w_row_nx = r_row - RW'(1);
        w_col_nx = r_col + RW'(1);
      end
    end else begin
      if (r_row == RW'(N - 1)) begin
        w_col_nx = r_col + RW'(1);
        w_up_nx  = 1'b1;
      end else if (r_col == '0) begin
        w_row_nx = r_row + RW'(1);
        w_up_nx  = 1'b1;
      end else begin
        w_row_nx = r_row + RW'(1);
        w_col_nx = r_col - RW'(1);
      end
    end
  end

  // Read side: output index, walker state and bank toggle at end of block.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_up      <= 1'b1;
    end else if (w_rd_hs) begin
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
        r_rd_idx  <= '0;
        r_row     <= '0;
        r_col     <= '0;
        r_up      <= 1'b1;
      end else begin
        r_rd_idx <= r_rd_idx + IW'(1);
        if (!w_rd_raster) begin
          r_row <= w_row_nx;
          r_col <= w_col_nx;
          r_up  <= w_up_nx;
        end
      end
    end
  end

`ifdef ZIGZAG_EOB_EN
  logic [IW:0] r_eob;
  logic [IW:0] w_eob_cur;

  // Output indices only increase, so the latest nonzero beat defines the end of block.
  assign w_eob_cur = (|data_out) ? ({1'b0, r_rd_idx} + (IW + 1)'(1)) : r_eob;
  assign eob_out   = valid_out ? w_eob_cur : '0;

  // Running end-of-block position within the block being drained.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_eob <= '0;
    end else if (w_rd_hs) begin
      r_eob <= w_rd_last ? '0 : w_eob_cur;
    end
  end
`endif

endmodule
